// File: rtl/rom_boot_loader.sv
// rom_boot_loader: copies LOAD_LEN bytes from a synchronous program ROM into data RAM
// starting at LOAD_BASE, holding the CPU in reset until the copy completes. A copy can be
// re-run from DONE by pulsing start.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start          (re)load request, honoured only in IDLE or DONE
//   rom_addr       ROM address (ROM registers its data on the next edge)
//   rom_enable     ROM output enable
//   rom_data       ROM read data, valid the cycle after rom_addr is sampled
//   ram_addr       RAM write address
//   ram_wdata      RAM write data
//   ram_we         RAM write request, held until ram_ready
//   ram_ready      RAM accepts the write on an edge with ram_we & ram_ready
//   cpu_reset      CPU reset, high until a copy completes
//   busy           copy in progress
//   done           last copy completed
//   byte_count     bytes written in the current or last copy
module rom_boot_loader #(
  parameter int unsigned ROM_ADDR_W = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RAM_ADDR_W = 16,
  parameter int unsigned LOAD_BASE  = 0,
  parameter int unsigned LOAD_LEN   = 22,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic                  rom_enable,
  input  logic [DATA_W-1:0]     rom_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic                  ram_we,
  input  logic                  ram_ready,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic [ROM_ADDR_W:0]   byte_count
);

  localparam int unsigned          CntW     = ROM_ADDR_W + 1;
  localparam logic [CntW-1:0]       LenCnt   = CntW'(LOAD_LEN);
  localparam logic [RAM_ADDR_W-1:0] BaseAddr = RAM_ADDR_W'(LOAD_BASE);

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                  launch;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + CntW'(1);
    launch     = 1'b0;

    unique case (state_q)
      // IDLE is only reachable through reset, so AUTO_START fires once per reset release.
      StIdle:  launch = AUTO_START || start;
      StFetch: state_d = StLatch;
      StLatch: begin
        wdata_d    = rom_data;
        ram_addr_d = BaseAddr + RAM_ADDR_W'(cnt_q);
        state_d    = StWrite;
      end
      StWrite: begin
        if (ram_ready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LenCnt) begin
            state_d = StDone;
          end else begin
            state_d    = StFetch;
            rom_addr_d = cnt_inc[ROM_ADDR_W-1:0];
          end
        end
      end
      StDone:  launch = start;
      default: state_d = StIdle;
    endcase

    if (launch) begin
      cnt_d = '0;
      if (LOAD_LEN == 0) begin
        state_d = StDone;
      end else begin
        state_d    = StFetch;
        rom_addr_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    rom_addr   = rom_addr_q;
    ram_addr   = ram_addr_q;
    ram_wdata  = wdata_q;
    byte_count = cnt_q;
    rom_enable = (state_q == StFetch) || (state_q == StLatch);
    ram_we     = (state_q == StWrite);
    busy       = (state_q == StFetch) || (state_q == StLatch) || (state_q == StWrite);
    done       = (state_q == StDone);
    cpu_reset  = (state_q != StDone);
  end

endmodule
